// File: rtl/iot_filter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iot_filter_if : sample-in / result-out bundle for iot_filter_core  rev 1.0 |
// +--------------------------------------------------------------------------+
interface iot_filter_if;
  logic         data_vld;
  logic [127:0] data;
  logic [2:0]   fn_sel;
  logic [127:0] iot_out;
  logic         valid;
  logic         round_done;

  modport master (
    output data_vld, data, fn_sel,
    input  iot_out, valid, round_done
  );

  modport slave (
    input  data_vld, data, fn_sel,
    output iot_out, valid, round_done
  );
endinterface
`default_nettype wire

// File: rtl/iot_filter_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iot_filter_core : round-based max/min/avg/range/peak filter       rev 1.0 |
// +--------------------------------------------------------------------------+
module iot_filter_core #(
  parameter logic [127:0] EXT_LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] EXT_HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] EXC_LO = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] EXC_HI = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter int           ROUND  = 8
) (
  input  logic         clk,
  input  logic         rst,
  iot_filter_if.slave  bus
);
  localparam int SHIFT = $clog2(ROUND);
  localparam int SW    = 128 + SHIFT;
  localparam logic [SHIFT-1:0] LAST = SHIFT'(ROUND - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_fn_prev;
  logic [SHIFT-1:0]  r_count;
  logic [127:0]      r_acc;
  logic [SW-1:0]     r_sum;
  logic [127:0]      r_peak;
  logic              r_peak_set;
  logic [127:0]      r_out;
  logic              r_valid;
  logic              r_round_done;

  logic              w_fn_chg;
  logic [SHIFT-1:0]  w_cnt;
  logic              w_first;
  logic              w_last;
  logic              w_use_min;
  logic [127:0]      w_acc_next;
  logic [SW-1:0]     w_sum_next;
  logic              w_in_ext;
  logic              w_in_exc;
  logic              w_peak_win;

  // A function change restarts the round, so the word arriving with it is word 0.
  assign w_fn_chg   = (bus.fn_sel != r_fn_prev);
  assign w_cnt      = w_fn_chg ? '0 : r_count;
  assign w_first    = (w_cnt == '0);
  assign w_last     = (w_cnt == LAST);
  assign w_use_min  = (bus.fn_sel == 3'd2) || (bus.fn_sel == 3'd7);

  always_comb begin
    w_acc_next = r_acc;
    if (w_first)
      w_acc_next = bus.data;
    else if (w_use_min && (bus.data < r_acc))
      w_acc_next = bus.data;
    else if (!w_use_min && (bus.data > r_acc))
      w_acc_next = bus.data;
  end

  assign w_sum_next = (w_first ? '0 : r_sum) + {{SHIFT{1'b0}}, bus.data};
  assign w_in_ext   = (bus.data > EXT_LO) && (bus.data < EXT_HI);
  assign w_in_exc   = (bus.data < EXC_LO) || (bus.data > EXC_HI);
  assign w_peak_win = !r_peak_set ||
                      (w_use_min ? (w_acc_next < r_peak) : (w_acc_next > r_peak));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_fn_prev    <= 3'd0;
      r_count      <= '0;
      r_acc        <= '0;
      r_sum        <= '0;
      r_peak       <= '0;
      r_peak_set   <= 1'b0;
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      r_fn_prev    <= bus.fn_sel;
      r_valid      <= 1'b0;
      r_round_done <= 1'b0;

      if (w_fn_chg) begin
        r_count    <= '0;
        r_acc      <= '0;
        r_sum      <= '0;
        r_peak_set <= 1'b0;
        r_state    <= ST_IDLE;
      end else if (r_state == ST_EMIT) begin
        r_state <= ST_IDLE;
      end

      if (bus.data_vld) begin
        r_count      <= w_last ? '0 : w_cnt + SHIFT'(1);
        r_acc        <= w_acc_next;
        r_sum        <= w_sum_next;
        r_state      <= w_last ? ST_EMIT : ST_ACCUM;
        r_round_done <= w_last;

        case (bus.fn_sel)
          3'd1, 3'd2: begin
            if (w_last) begin
              r_valid <= 1'b1;
              r_out   <= w_acc_next;
            end
          end
          3'd3: begin
            if (w_last) begin
              r_valid <= 1'b1;
              r_out   <= w_sum_next[SW-1:SHIFT];
            end
          end
          3'd4: begin
            if (w_in_ext) begin
              r_valid <= 1'b1;
              r_out   <= bus.data;
            end
          end
          3'd5: begin
            if (w_in_exc) begin
              r_valid <= 1'b1;
              r_out   <= bus.data;
            end
          end
          3'd6, 3'd7: begin
            if (w_last && w_peak_win) begin
              r_peak     <= w_acc_next;
              r_peak_set <= 1'b1;
              r_valid    <= 1'b1;
              r_out      <= w_acc_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.iot_out    = r_out;
  assign bus.valid      = r_valid;
  assign bus.round_done = r_round_done;
endmodule
`default_nettype wire

// File: tb/tb_iot_filter_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iot_filter_core : scoreboard bench for iot_filter_core         rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_iot_filter_core;
  localparam logic [127:0] EXT_LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] EXT_HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] EXC_LO = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] EXC_HI = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] ONES   = {128{1'b1}};

  typedef struct {
    int unsigned  cyc;
    logic [127:0] val;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  int unsigned  cyc = 0;
  int           n_checks = 0;
  int           n_fails = 0;
  exp_t         vq[$];
  int unsigned  rq[$];
  logic [127:0] w8 [8];

  iot_filter_if bus();

  iot_filter_core dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle after the producing edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid) begin
        if (vq.size() == 0) begin
          chk("unexpected_valid", bus.iot_out, '0);
        end else begin
          exp_t e;
          e = vq.pop_front();
          chk("valid_cycle", 128'(cyc), 128'(e.cyc));
          chk("iot_out", bus.iot_out, e.val);
        end
      end
      if (bus.round_done) begin
        if (rq.size() == 0)
          chk("unexpected_round_done", 128'(cyc), '0);
        else
          chk("round_done_cycle", 128'(cyc), 128'(rq.pop_front()));
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [127:0] w,
                      input bit ev, input logic [127:0] ex, input bit rd);
    exp_t e;
    @(negedge clk);
    bus.fn_sel   = f;
    bus.data     = w;
    bus.data_vld = 1'b1;
    if (ev) begin
      e.cyc = cyc + 1;
      e.val = ex;
      vq.push_back(e);
    end
    if (rd) rq.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_vld = 1'b0;
    end
  endtask

  task automatic round(input logic [2:0] f, input bit ev, input logic [127:0] ex, input int gap);
    for (int i = 0; i < 8; i++) begin
      send(f, w8[i], ev && (i == 7), ex, i == 7);
      idle(gap);
    end
  endtask

  task automatic fill_perm(input logic [127:0] base);
    for (int i = 0; i < 8; i++) w8[i] = base + 128'((i * 5) % 8);
  endtask

  task automatic fill_change_words;
    w8[0] = 128'h20; w8[1] = 128'h1C; w8[2] = 128'h25; w8[3] = 128'h30;
    w8[4] = 128'h21; w8[5] = 128'h1D; w8[6] = 128'h40; w8[7] = 128'h22;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_vld = 1'b0;
    bus.data     = '0;
    bus.fn_sel   = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_iot_out", bus.iot_out, '0);
    chk("reset_valid", 128'(bus.valid), '0);
    chk("reset_round_done", 128'(bus.round_done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Max over 0x10..0x17 back-to-back.
    for (int i = 0; i < 8; i++) w8[i] = 128'h10 + 128'(i);
    round(3'd1, 1'b1, 128'h17, 0);
    idle(2);

    // Average: seven 1s and one 9, then all-ones round without overflow loss.
    for (int i = 0; i < 8; i++) w8[i] = 128'h1;
    w8[5] = 128'h9;
    round(3'd3, 1'b1, 128'h2, 0);
    for (int i = 0; i < 8; i++) w8[i] = ONES;
    round(3'd3, 1'b1, ONES, 0);
    idle(2);

    // Extract strict bounds.
    send(3'd4, EXT_LO,          1'b0, '0,              1'b0);
    send(3'd4, EXT_LO + 128'd1, 1'b1, EXT_LO + 128'd1, 1'b0);
    send(3'd4, EXT_HI - 128'd1, 1'b1, EXT_HI - 128'd1, 1'b0);
    send(3'd4, EXT_HI,          1'b0, '0,              1'b0);
    idle(2);

    // Exclude band edges.
    send(3'd5, EXC_LO - 128'd1, 1'b1, EXC_LO - 128'd1, 1'b0);
    send(3'd5, EXC_LO,          1'b0, '0,              1'b0);
    send(3'd5, EXC_HI,          1'b0, '0,              1'b0);
    send(3'd5, EXC_HI + 128'd1, 1'b1, EXC_HI + 128'd1, 1'b0);
    idle(2);

    // No function: never valid.
    for (int i = 0; i < 5; i++) send(3'd0, 128'(i + 3), 1'b0, '0, 1'b0);
    idle(2);

    // Peak-max with round maxima 0x50, 0x40, 0x60.
    fill_perm(128'h50 - 128'd7); round(3'd6, 1'b1, 128'h50, 0);
    fill_perm(128'h40 - 128'd7); round(3'd6, 1'b0, '0,      0);
    fill_perm(128'h60 - 128'd7); round(3'd6, 1'b1, 128'h60, 0);
    idle(2);

    // Peak-min with round minima 0x50, 0x60, 0x40.
    fill_perm(128'h50); round(3'd7, 1'b1, 128'h50, 0);
    fill_perm(128'h60); round(3'd7, 1'b0, '0,      0);
    fill_perm(128'h40); round(3'd7, 1'b1, 128'h40, 0);
    idle(2);

    // Reset mid-round discards the partial round.
    for (int i = 0; i < 5; i++) send(3'd2, 128'(i + 1), 1'b0, '0, 1'b0);
    @(negedge clk);
    bus.data_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_iot_out", bus.iot_out, '0);
    chk("midreset_valid", 128'(bus.valid), '0);
    chk("midreset_round_done", 128'(bus.round_done), '0);
    repeat (2) @(negedge clk);
    chk("midreset_hold_iot_out", bus.iot_out, '0);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) w8[i] = 128'h37 - 128'(i);
    round(3'd2, 1'b1, 128'h30, 0);
    idle(2);

    // fn change 1 -> 2 after three words, back-to-back then gapped.
    for (int i = 0; i < 3; i++) send(3'd1, 128'(i + 1), 1'b0, '0, 1'b0);
    fill_change_words();
    round(3'd2, 1'b1, 128'h1C, 0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      send(3'd1, 128'(i + 1), 1'b0, '0, 1'b0);
      idle(2);
    end
    round(3'd2, 1'b1, 128'h1C, 2);
    idle(5);

    chk("valid_queue_drained", 128'(vq.size()), '0);
    chk("round_done_queue_drained", 128'(rq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire
